// File: rtl/move_score_collector_if.sv
// Evaluator-in / result-out handshake bundle for move_score_collector.
// Optional macro EARLY_LAST_EN adds the in_last sideband on the input stream.
interface move_score_collector_if #(
  parameter int W = 6
) ();
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_score;
  logic [W-1:0] in_pos;
`ifdef EARLY_LAST_EN
  logic         in_last;
`endif
  logic         best_valid;
  logic         best_ready;
  logic [W-1:0] best_score;
  logic [W-1:0] best_pos;

`ifdef EARLY_LAST_EN
  modport master (
    output in_valid, in_score, in_pos, in_last, best_ready,
    input  in_ready, best_valid, best_score, best_pos
  );
  modport slave (
    input  in_valid, in_score, in_pos, in_last, best_ready,
    output in_ready, best_valid, best_score, best_pos
  );
`else
  modport master (
    output in_valid, in_score, in_pos, best_ready,
    input  in_ready, best_valid, best_score, best_pos
  );
  modport slave (
    input  in_valid, in_score, in_pos, best_ready,
    output in_ready, best_valid, best_score, best_pos
  );
`endif
endinterface

// File: rtl/move_score_collector.sv
// Fills a 64-entry score/position bank for the max-score arbiter tree and returns its winner.
// Optional macro EARLY_LAST_EN: a beat with in_last ends the sweep early.
module move_score_collector #(
  parameter int N_ENTRIES     = 64,
  parameter int W             = 6,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  move_score_collector_if.slave  bus,
  output logic [N_ENTRIES*W-1:0] scores_flat,
  output logic [N_ENTRIES*W-1:0] pos_flat,
  output logic                   bank_valid,
  input  logic [W-1:0]           arb_score,
  input  logic [W-1:0]           arb_pos,
  output logic                   busy
);
  localparam int CW = $clog2(N_ENTRIES);
  localparam int SW = 4;
  localparam logic [CW-1:0] LAST_IDX    = CW'(N_ENTRIES - 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    SETTLE  = 2'd2,
    PRESENT = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SW-1:0]          settle_q, settle_d;
  logic [N_ENTRIES*W-1:0] scores_q, scores_d;
  logic [N_ENTRIES*W-1:0] pos_q, pos_d;
  logic                   bank_valid_q, bank_valid_d;
  logic                   best_valid_q, best_valid_d;
  logic [W-1:0]           best_score_q, best_score_d;
  logic [W-1:0]           best_pos_q, best_pos_d;
  logic                   in_ready_q, in_ready_d;
  logic                   busy_q, busy_d;
  logic                   last_beat_s;

  // Position field of every entry preset to its own index.
  function automatic logic [N_ENTRIES*W-1:0] preset_pos();
    logic [N_ENTRIES*W-1:0] v;
    v = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      v[W*i +: W] = W'(i);
    end
    return v;
  endfunction

  // Decides whether the current FILL transfer closes the sweep.
  always_comb begin
`ifdef EARLY_LAST_EN
    last_beat_s = (cnt_q == LAST_IDX) || bus.in_last;
`else
    last_beat_s = (cnt_q == LAST_IDX);
`endif
  end

  // Next-state, bank update and result capture.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    settle_d     = settle_q;
    scores_d     = scores_q;
    pos_d        = pos_q;
    bank_valid_d = bank_valid_q;
    best_valid_d = best_valid_q;
    best_score_d = best_score_q;
    best_pos_d   = best_pos_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          scores_d     = '0;
          pos_d        = preset_pos();
          cnt_d        = '0;
          bank_valid_d = 1'b0;
          state_d      = FILL;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        // A restart wins over a beat arriving on the same edge.
        if (start) begin
          scores_d     = '0;
          pos_d        = preset_pos();
          cnt_d        = '0;
          bank_valid_d = 1'b0;
          state_d      = FILL;
        end else if (bus.in_valid) begin
          scores_d[W*cnt_q +: W] = bus.in_score;
          pos_d[W*cnt_q +: W]    = bus.in_pos;
          if (last_beat_s) begin
            bank_valid_d = 1'b1;
            settle_d     = SETTLE_LOAD;
            state_d      = SETTLE;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end
      SETTLE: begin
        if (settle_q == SW'(0)) begin
          best_score_d = arb_score;
          best_pos_d   = arb_pos;
          best_valid_d = 1'b1;
          state_d      = PRESENT;
        end else begin
          settle_d = settle_q - SW'(1);
          state_d  = SETTLE;
        end
      end
      PRESENT: begin
        if (bus.best_ready) begin
          best_valid_d = 1'b0;
          bank_valid_d = 1'b0;
          state_d      = IDLE;
        end else begin
          state_d = PRESENT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d = (state_d == FILL);
    busy_d     = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      settle_q     <= '0;
      scores_q     <= '0;
      pos_q        <= preset_pos();
      bank_valid_q <= 1'b0;
      best_valid_q <= 1'b0;
      best_score_q <= '0;
      best_pos_q   <= '0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      settle_q     <= settle_d;
      scores_q     <= scores_d;
      pos_q        <= pos_d;
      bank_valid_q <= bank_valid_d;
      best_valid_q <= best_valid_d;
      best_score_q <= best_score_d;
      best_pos_q   <= best_pos_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign scores_flat    = scores_q;
  assign pos_flat       = pos_q;
  assign bank_valid     = bank_valid_q;
  assign busy           = busy_q;
  assign bus.in_ready   = in_ready_q;
  assign bus.best_valid = best_valid_q;
  assign bus.best_score = best_score_q;
  assign bus.best_pos   = best_pos_q;
endmodule

// File: tb/tb_move_score_collector.sv
// Directed-vector bench for move_score_collector with a behavioural max-score tree.
// Build with EARLY_LAST_EN defined to also exercise the early-last sequence.
module tb_move_score_collector;
  localparam int N  = 64;
  localparam int W  = 6;
  localparam int BW = N * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [BW-1:0] scores_flat;
  logic [BW-1:0] pos_flat;
  logic          bank_valid;
  logic          busy;
  logic [W-1:0]  arb_score;
  logic [W-1:0]  arb_pos;
  int            n_tests = 0;
  int            n_fail  = 0;

  always #5 clk = ~clk;

  move_score_collector_if #(.W(W)) bus ();

  move_score_collector #(
    .N_ENTRIES(N), .W(W), .SETTLE_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .scores_flat(scores_flat), .pos_flat(pos_flat), .bank_valid(bank_valid),
    .arb_score(arb_score), .arb_pos(arb_pos), .busy(busy)
  );

  // Reference arbiter tree: highest score, ties toward the higher entry index.
  always_comb begin
    logic [W-1:0] bs;
    logic [W-1:0] bp;
    bs = scores_flat[W-1:0];
    bp = pos_flat[W-1:0];
    for (int i = 1; i < N; i++) begin
      if (scores_flat[W*i +: W] >= bs) begin
        bs = scores_flat[W*i +: W];
        bp = pos_flat[W*i +: W];
      end
    end
    arb_score = bs;
    arb_pos   = bp;
  end

  typedef struct {
    int           pat;
    logic [W-1:0] xm;
    bit           stall;
    int           hold;
    bit           early_ready;
    logic [W-1:0] exp_score;
    logic [W-1:0] exp_pos;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [W-1:0] score_of(input int pat, input int i);
    case (pat)
      0:       return W'(i % 50);
      1:       return 6'd17;
      2:       return (i == 5) ? 6'd40 : 6'd3;
      3:       return W'(63 - i);
      4:       return 6'd0;
      5:       return W'(i);
      6:       return 6'd60;
      default: return 6'd0;
    endcase
  endfunction

  function automatic logic [W-1:0] pos_of(input logic [W-1:0] xm, input int i);
    logic [W-1:0] p;
    p = W'(i);
    return p ^ xm;
  endfunction

  function automatic logic [BW-1:0] preset_ref();
    logic [BW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[W*i +: W] = W'(i);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_wide(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    chk({tag, "_bank_valid"}, {31'd0, bank_valid}, 32'd0);
    chk({tag, "_best_valid"}, {31'd0, bus.best_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_best"}, {20'd0, bus.best_score, bus.best_pos}, 32'd0);
    chk_wide({tag, "_scores"}, scores_flat, '0);
    chk_wide({tag, "_pos"}, pos_flat, preset_ref());
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sends n beats; a beat counts only when in_valid and in_ready meet at an edge.
  task automatic send_beats(input int pat, input logic [W-1:0] xm, input int n, input bit stall);
    int i;
    int guard;
    bit xfer;
    i = 0;
    guard = 0;
    while (i < n && guard < 4000) begin
      bus.in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_score = score_of(pat, i);
      bus.in_pos   = pos_of(xm, i);
      xfer = bus.in_valid && bus.in_ready;
      tick();
      if (xfer) i++;
      guard++;
    end
    bus.in_valid = 1'b0;
    chk("beats_sent", i, n);
  endtask

  task automatic check_bank(input string tag, input int pat, input logic [W-1:0] xm);
    logic [BW-1:0] es;
    logic [BW-1:0] ep;
    for (int i = 0; i < N; i++) begin
      es[W*i +: W] = score_of(pat, i);
      ep[W*i +: W] = pos_of(xm, i);
    end
    chk_wide({tag, "_bank_scores"}, scores_flat, es);
    chk_wide({tag, "_bank_pos"}, pos_flat, ep);
  endtask

  // Waits for the result, checks it, holds it for `hold` cycles, then accepts it.
  task automatic run_result(input string tag, input logic [W-1:0] es, input logic [W-1:0] ep,
                            input int hold, input bit early_ready);
    int k;
    chk({tag, "_bank_valid"}, {31'd0, bank_valid}, 32'd1);
    bus.best_ready = early_ready;
    k = 0;
    while (!bus.best_valid && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_settle_edges"}, k, 32'd2);
    chk({tag, "_best_score"}, {26'd0, bus.best_score}, {26'd0, es});
    chk({tag, "_best_pos"}, {26'd0, bus.best_pos}, {26'd0, ep});
    for (int h = 0; h < hold; h++) begin
      start = (h == 3);
      tick();
      chk({tag, "_hold"}, {19'd0, bus.best_valid, bus.best_score, bus.best_pos},
          {19'd0, 1'b1, es, ep});
    end
    start = 1'b0;
    bus.best_ready = 1'b1;
    tick();
    bus.best_ready = 1'b0;
    chk({tag, "_after_accept"}, {29'd0, bus.best_valid, busy, bank_valid}, 32'd0);
    tick();
    tick();
    chk({tag, "_single_result"}, {30'd0, bus.best_valid, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_score = '0;
    bus.in_pos = '0;
    bus.best_ready = 1'b0;
`ifdef EARLY_LAST_EN
    bus.in_last = 1'b0;
`endif
    vecs[0] = '{pat: 0, xm: 6'h00, stall: 1'b0, hold: 0,  early_ready: 1'b0, exp_score: 6'd49, exp_pos: 6'd49};
    vecs[1] = '{pat: 0, xm: 6'h2A, stall: 1'b1, hold: 10, early_ready: 1'b0, exp_score: 6'd49, exp_pos: 6'd27};
    vecs[2] = '{pat: 1, xm: 6'h00, stall: 1'b0, hold: 0,  early_ready: 1'b1, exp_score: 6'd17, exp_pos: 6'd63};
    vecs[3] = '{pat: 2, xm: 6'h00, stall: 1'b1, hold: 3,  early_ready: 1'b0, exp_score: 6'd40, exp_pos: 6'd5};
    vecs[4] = '{pat: 3, xm: 6'h00, stall: 1'b0, hold: 0,  early_ready: 1'b1, exp_score: 6'd63, exp_pos: 6'd0};
    vecs[5] = '{pat: 4, xm: 6'h15, stall: 1'b0, hold: 0,  early_ready: 1'b0, exp_score: 6'd0,  exp_pos: 6'd42};
    vecs[6] = '{pat: 5, xm: 6'h00, stall: 1'b1, hold: 0,  early_ready: 1'b0, exp_score: 6'd63, exp_pos: 6'd63};

    tick();
    tick();
    check_reset_state("reset");
    rst = 1'b0;
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    for (int v = 0; v < 7; v++) begin
      pulse_start();
      chk($sformatf("vec%0d_fill_ready", v), {30'd0, bus.in_ready, busy}, 32'd3);
      send_beats(vecs[v].pat, vecs[v].xm, N, vecs[v].stall);
      check_bank($sformatf("vec%0d", v), vecs[v].pat, vecs[v].xm);
      run_result($sformatf("vec%0d", v), vecs[v].exp_score, vecs[v].exp_pos,
                 vecs[v].hold, vecs[v].early_ready);
    end

    // Restart mid-fill, with a beat offered on the restart edge that must be dropped.
    pulse_start();
    send_beats(6, 6'h00, 20, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_score = 6'd63;
    bus.in_pos = 6'd0;
    pulse_start();
    bus.in_valid = 1'b0;
    chk_wide("restart_cleared", scores_flat, '0);
    send_beats(2, 6'h00, N, 1'b0);
    check_bank("restart", 2, 6'h00);
    run_result("restart", 6'd40, 6'd5, 0, 1'b0);

    // Reset while settling.
    pulse_start();
    send_beats(0, 6'h00, N, 1'b0);
    chk("settle_bank_valid", {31'd0, bank_valid}, 32'd1);
    rst = 1'b1;
    tick();
    check_reset_state("rst_settle");
    rst = 1'b0;

    // Reset while presenting.
    pulse_start();
    send_beats(1, 6'h00, N, 1'b0);
    tick();
    tick();
    chk("present_best_valid", {31'd0, bus.best_valid}, 32'd1);
    rst = 1'b1;
    tick();
    check_reset_state("rst_present");
    rst = 1'b0;
    tick();

    pulse_start();
    send_beats(0, 6'h00, N, 1'b0);
    check_bank("post_rst", 0, 6'h00);
    run_result("post_rst", 6'd49, 6'd49, 0, 1'b0);

`ifdef EARLY_LAST_EN
    begin
      logic [BW-1:0] es;
      logic [BW-1:0] ep;
      es = '0;
      ep = preset_ref();
      pulse_start();
      for (int j = 0; j < 3; j++) begin
        bus.in_valid = 1'b1;
        bus.in_score = (j == 0) ? 6'd5 : ((j == 1) ? 6'd9 : 6'd2);
        bus.in_pos = W'(10 + j);
        bus.in_last = (j == 2);
        es[W*j +: W] = bus.in_score;
        ep[W*j +: W] = bus.in_pos;
        tick();
      end
      bus.in_valid = 1'b0;
      bus.in_last = 1'b0;
      chk_wide("early_bank_scores", scores_flat, es);
      chk_wide("early_bank_pos", pos_flat, ep);
      run_result("early", 6'd9, 6'd11, 0, 1'b0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/move_score_collector.md
Name: move_score_collector

Overview:
- Sequential front end for the 64-way max-score arbiter tree.
- Accepts one score/position beat per square from the move evaluator over a valid/ready stream, filling a 64-entry bank that drives the tree's inputs.
- Once the bank is full, it waits a fixed settle time for the combinational tree, captures the winning score and position, and presents them to the search controller over a valid/ready handshake.

Parameters:
- N_ENTRIES, 64, number of bank entries; equals the arbiter tree width.
- W, 6, width of both the score and the position fields.
- SETTLE_CYCLES, 2, cycles to wait after the bank fills before the tree result is sampled; legal range 1..15.

Ports:
- clk  input  1  single clock.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  pulse that begins a new sweep.
- in_valid  input  1  evaluator beat valid.
- in_ready  output  1  collector can accept a beat.
- in_score  input  W  score for the current entry.
- in_pos  input  W  square position for the current entry.
- scores_flat  output  N_ENTRIES*W  bank scores; entry i is at bits [W*i+W-1 : W*i]; drives tree in(i+1).
- pos_flat  output  N_ENTRIES*W  bank positions, same packing; drives tree inpos_(i+1).
- bank_valid  output  1  bank is complete and stable.
- arb_score  input  W  tree output score (combinational).
- arb_pos  input  W  tree output position (combinational).
- best_valid  output  1  result available.
- best_ready  input  1  controller accepts the result.
- best_score  output  W  registered winning score.
- best_pos  output  W  registered winning position.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - State is IDLE; the write counter is 0.
  - Every bank score is 0, and bank position i is i.
  - in_ready, bank_valid, best_valid and busy are 0; best_score and best_pos are 0.
- States: IDLE, FILL, SETTLE, PRESENT.
- IDLE:
  - start=1 → FILL.
  - On the same edge: all scores are cleared to 0, all positions are preset to their entry index, the counter is 0, and bank_valid goes to 0.
- FILL:
  - in_ready=1.
  - A beat transfers on an edge where in_valid && in_ready. The beat writes entry[counter] (score and position) and the counter increments.
  - The transfer with counter=N_ENTRIES-1 moves the block to SETTLE, sets bank_valid=1, and loads the settle counter with SETTLE_CYCLES-1.
  - start=1 in FILL restarts the sweep: same clear/preset as from IDLE, stay in FILL, and any beat on that edge is dropped.
  - in_valid may stall indefinitely with no effect.
- SETTLE:
  - in_ready=0 and the bank is frozen.
  - The settle counter decrements each cycle.
  - On the edge where it is 0: best_score<=arb_score, best_pos<=arb_pos, best_valid<=1, → PRESENT.
  - Net effect: best_valid rises exactly SETTLE_CYCLES edges after bank_valid rises.
- PRESENT:
  - best_valid, best_score and best_pos are held stable until best_ready=1.
  - On that edge: best_valid<=0, bank_valid<=0, → IDLE. The bank contents are retained.
  - best_ready may already be high when best_valid rises; the transfer then occurs on the next edge.
- start is ignored in SETTLE and PRESENT.
- Ties are resolved by the tree toward the higher entry index. The collector passes the tree result through unchanged.
- rst asserted in any state returns the block to its reset values on that edge. No partial result is ever presented.

Optional Feature:
- Macro: EARLY_LAST_EN.
- With the macro defined:
  - Extra port in_last (input, 1).
  - A transfer in FILL with in_last=1 writes its entry and then goes directly to SETTLE with bank_valid=1.
  - Unwritten entries keep score 0 and position = index.
  - The last beat is honoured even when counter=N_ENTRIES-1.
- Without the macro: the port is absent, and a sweep always needs exactly N_ENTRIES beats.

Test Plan:
- Full sweep: start, then 64 beats with score=i mod 50 and pos=i, where entry 49 has score 49 → bank_valid rises; best_valid rises 2 edges later; best_score=49, best_pos=49; after best_ready, state is IDLE and busy=0.
- Backpressure and stalls: toggle in_valid randomly; hold best_ready=0 for 10 cycles after best_valid → counter advances only on transfers; best_* stay stable for all 10 cycles; exactly one result is delivered.
- Tie: all 64 beats score=17 with pos=i → best_score=17, best_pos=63.
- Restart: start, 20 beats, start again, then 64 beats all with score 3 except entry 5 with score 40 → best_score=40, best_pos=5; no stale data from the first 20 beats.
- Reset mid-operation: assert rst in SETTLE, and separately in PRESENT → next cycle all outputs are at reset values; a subsequent full sweep gives the correct result.
- EARLY_LAST_EN: 3 beats with scores 5, 9, 2 at positions 10, 11, 12, and in_last on the third → best_score=9, best_pos=11, and bank entries 3..63 have score 0 with position = index.
